// File: rtl/spi_cfg_arbiter.sv
// Two-requester write arbiter driving an SPI mode-0 master toward a register-file peripheral.
// Each grant latches a 16-bit frame {1, addr[6:0], data[7:0]} and sends it MSB first.
// Out-of-range addresses are rejected without touching the SPI lines.
module spi_cfg_arbiter #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] ack,
    output logic       rej,
    output logic       busy,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StTrail, StGap} state_e;

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
    localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);
    localparam logic [6:0] MaxAddr = 7'h04;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] shreg_q;
    logic        grant_q;
    logic        rr_q;
    logic [1:0]  ack_q;
    logic        rej_q;
    logic        sclk_q;
    logic        ncs_q;
    logic        copi_q;

    logic        gnt_sel;
    logic [15:0] gnt_frame;

    // Pick the requester to grant: round-robin pointer breaks ties, else the lone requester.
    always_comb begin
        gnt_sel   = (req == 2'b11) ? rr_q : req[1];
        gnt_frame = gnt_sel ? {1'b1, addr1, data1} : {1'b1, addr0, data0};
    end

    // Single FSM: arbitration, frame shifting, trailing hold and inter-frame gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            bit_cnt_q <= 5'd0;
            shreg_q   <= 16'd0;
            grant_q   <= 1'b0;
            rr_q      <= 1'b0;
            ack_q     <= 2'b00;
            rej_q     <= 1'b0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            copi_q    <= 1'b0;
        end else begin
            ack_q <= 2'b00;
            rej_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        grant_q <= gnt_sel;
                        rr_q    <= ~gnt_sel;
                        shreg_q <= gnt_frame;
                        if (gnt_frame[14:8] > MaxAddr) begin
                            // Rejected: ack immediately, never assert ncs.
                            ack_q   <= gnt_sel ? 2'b10 : 2'b01;
                            rej_q   <= 1'b1;
                            cnt_q   <= GapLast;
                            state_q <= StGap;
                        end else begin
                            ncs_q     <= 1'b0;
                            sclk_q    <= 1'b0;
                            copi_q    <= gnt_frame[15];
                            cnt_q     <= DivLast;
                            bit_cnt_q <= 5'd0;
                            state_q   <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    if (cnt_q == 8'd0) begin
                        sclk_q  <= 1'b1;
                        cnt_q   <= DivLast;
                        state_q <= StShift;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StShift: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        cnt_q <= DivLast;
                        if (sclk_q) begin
                            // End of a high phase: advance copi at the start of the low phase.
                            sclk_q    <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd15) begin
                                copi_q  <= 1'b0;
                                state_q <= StTrail;
                            end else begin
                                copi_q  <= shreg_q[14];
                                shreg_q <= {shreg_q[14:0], 1'b0};
                            end
                        end else begin
                            sclk_q <= 1'b1;
                        end
                    end
                end
                StTrail: begin
                    if (cnt_q == 8'd0) begin
                        ncs_q   <= 1'b1;
                        ack_q   <= grant_q ? 2'b10 : 2'b01;
                        cnt_q   <= GapLast;
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack  = ack_q;
    assign rej  = rej_q;
    assign busy = (state_q != StIdle);
    assign sclk = sclk_q;
    assign ncs  = ncs_q;
    assign copi = copi_q;

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Bench for spi_cfg_arbiter: timeline reference model checked every cycle, a peripheral-side
// frame decoder, directed scenarios with literal expectations, then randomized traffic.
module tb_spi_cfg_arbiter;

    localparam int D   = 2;
    localparam int GAP = 2;
    localparam int L   = 33 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_r = 2'b00;
    logic [6:0] addr0_r = 7'd0;
    logic [6:0] addr1_r = 7'd0;
    logic [7:0] data0_r = 8'd0;
    logic [7:0] data1_r = 8'd0;
    logic [1:0] ack;
    logic       rej;
    logic       busy;
    logic       sclk;
    logic       ncs;
    logic       copi;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    spi_cfg_arbiter #(
        .CLK_DIV   (D),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req_r),
        .addr0(addr0_r),
        .addr1(addr1_r),
        .data0(data0_r),
        .data1(data1_r),
        .ack  (ack),
        .rej  (rej),
        .busy (busy),
        .sclk (sclk),
        .ncs  (ncs),
        .copi (copi)
    );

    always #5 clk = ~clk;

    // Decoded frames as seen by the peripheral.
    typedef struct {
        logic [15:0] data;
        int          bits;
        int          len;
        logic [1:0]  ack_at_rise;
        int          gap_before;
    } frame_t;

    frame_t     frames[$];
    logic [2:0] ack_ev[$];
    int         mon_bits = 0;

    // Reference model: a granted transaction is a timeline indexed by t (cycles since grant).
    bit          m_ready = 0;
    bit          m_active = 0;
    bit          m_rej = 0;
    bit          m_g = 0;
    bit          m_rr = 0;
    logic [15:0] m_f = 16'd0;
    int          m_t = 0;
    int          m_end = 0;

    function automatic logic [6:0] model_out();
        logic [1:0] oh;
        int k, b;
        logic sc, co;
        oh = m_g ? 2'b10 : 2'b01;
        if (!m_active) return 7'b00_0_0_0_1_0;
        if (m_rej) return {(m_t == 0) ? oh : 2'b00, m_t == 0, 1'b1, 1'b0, 1'b1, 1'b0};
        sc = 1'b0;
        co = 1'b0;
        if (m_t < D) begin
            co = m_f[15];
        end else if (m_t < 32 * D) begin
            k  = m_t - D;
            b  = k / (2 * D);
            sc = (k % (2 * D)) < D;
            if (sc) co = m_f[15 - b];
            else    co = m_f[14 - b];
        end
        return {(m_t == L) ? oh : 2'b00, 1'b0, 1'b1, sc, (m_t >= L), co};
    endfunction

    // Compare process: model steps on each rising edge, outputs checked on the falling edge.
    initial begin : compare_proc
        logic [6:0] exp_v, got_v;
        logic prev_ncs, prev_sclk;
        logic [15:0] cur;
        int bits, len, high_run, gap_b;
        prev_ncs = 1'b1; prev_sclk = 1'b0; cur = 16'd0;
        bits = 0; len = 0; high_run = 0; gap_b = 0;
        forever begin
            @(posedge clk);
            cycle++;
            if (!rst_n) begin
                m_active = 0;
                m_rr     = 0;
                m_ready  = 1;
            end else if (m_ready) begin
                if (m_active) begin
                    m_t++;
                    if (m_t == m_end) m_active = 0;
                end else if (req_r != 2'b00) begin
                    m_g    = (req_r == 2'b11) ? m_rr : req_r[1];
                    m_rr   = !m_g;
                    m_f    = m_g ? {1'b1, addr1_r, data1_r} : {1'b1, addr0_r, data0_r};
                    m_rej  = m_f[14:8] > 7'h04;
                    m_active = 1;
                    m_t    = 0;
                    m_end  = m_rej ? GAP : L + GAP;
                end
            end
            @(negedge clk);
            if (m_ready) begin
                exp_v = model_out();
                got_v = {ack, rej, busy, sclk, ncs, copi};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL cycle_model @%0d: {ack,rej,busy,sclk,ncs,copi} got %b expected %b",
                             cycle, got_v, exp_v);
                end
                // Peripheral-side decoder.
                if (prev_ncs && !ncs) begin
                    cur = 16'd0; bits = 0; len = 0; gap_b = high_run;
                end
                if (!ncs) begin
                    len++;
                    if (!prev_sclk && sclk) begin
                        cur = {cur[14:0], copi};
                        bits++;
                    end
                end
                if (ncs && !prev_ncs) begin
                    frames.push_back('{data: cur, bits: bits, len: len, ack_at_rise: ack,
                                       gap_before: gap_b});
                end
                mon_bits = bits;
                if (ncs) high_run++;
                else     high_run = 0;
                if (ack != 2'b00) ack_ev.push_back({ack, rej});
                prev_ncs  = ncs;
                prev_sclk = sclk;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until n frames are decoded; optionally release each request on its ack.
    task automatic wait_frames(input int n, input int budget, input bit drop);
        int c = 0;
        while (frames.size() < n && c < budget) begin
            tick();
            if (drop) req_r = req_r & ~ack;
            c++;
        end
        if (frames.size() < n) begin
            errors++;
            $display("FAIL wait_frames: got %0d frames expected %0d", frames.size(), n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_r = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : driver
        int base;
        int c;
        do_reset();
        check("reset_ncs",  32'(ncs),  32'd1);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ack",  32'(ack),  32'd0);

        // Single valid write.
        base = frames.size();
        addr0_r = 7'h04; data0_r = 8'hA5; req_r = 2'b01;
        wait_frames(base + 1, 300, 1);
        if (frames.size() > base) begin
            check("single_frame", 32'(frames[base].data), 32'h84A5);
            check("single_len",   32'(frames[base].len),  32'd66);
            check("single_bits",  32'(frames[base].bits), 32'd16);
            check("single_ack",   32'(frames[base].ack_at_rise), 32'd1);
        end
        repeat (5) tick();

        // Simultaneous requests from reset: requester 0 first.
        do_reset();
        base = frames.size();
        addr0_r = 7'h00; data0_r = 8'hFF; addr1_r = 7'h02; data1_r = 8'h0F; req_r = 2'b11;
        wait_frames(base + 2, 400, 1);
        if (frames.size() > base + 1) begin
            check("rr_frame0", 32'(frames[base].data),            32'h80FF);
            check("rr_ack0",   32'(frames[base].ack_at_rise),     32'd1);
            check("rr_frame1", 32'(frames[base + 1].data),        32'h820F);
            check("rr_ack1",   32'(frames[base + 1].ack_at_rise), 32'd2);
            check("rr_gap",    32'(frames[base + 1].gap_before >= GAP), 32'd1);
        end
        repeat (5) tick();

        // Both held high for four frames: grants alternate 0,1,0,1.
        base = frames.size();
        addr0_r = 7'h01; data0_r = 8'h11; addr1_r = 7'h03; data1_r = 8'h33; req_r = 2'b11;
        wait_frames(base + 4, 800, 0);
        req_r = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (frames.size() > base + i) begin
                check("alt_frame", 32'(frames[base + i].data), (i % 2 == 1) ? 32'h8333 : 32'h8111);
                check("alt_gap", 32'(frames[base + i].gap_before >= GAP), 32'd1);
            end
        end
        repeat (5) tick();

        // Rejected address: no ncs activity, ack=10 with rej.
        base = frames.size();
        ack_ev.delete();
        addr1_r = 7'h05; data1_r = 8'h77; req_r = 2'b10;
        c = 0;
        while (ack_ev.size() == 0 && c < 50) begin
            tick();
            req_r = req_r & ~ack;
            c++;
        end
        check("rej_event", (ack_ev.size() > 0) ? 32'(ack_ev[0]) : 32'hFFFF, 32'b101);
        check("rej_no_frame", 32'(frames.size()), 32'(base));
        addr0_r = 7'h02; data0_r = 8'h5A; req_r = 2'b01;
        wait_frames(base + 1, 300, 1);
        if (frames.size() > base) check("after_rej_frame", 32'(frames[base].data), 32'h825A);
        repeat (5) tick();

        // Reset during bit 7 aborts the frame; the retried request completes.
        addr0_r = 7'h03; data0_r = 8'h3C; req_r = 2'b01;
        c = 0;
        while (!(mon_bits == 8 && ncs == 1'b0) && c < 300) begin
            tick();
            c++;
        end
        check("abort_reached_bit7", 32'(mon_bits), 32'd8);
        rst_n = 1'b0;
        tick();
        check("abort_ncs",  32'(ncs),  32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_ack",  32'(ack),  32'd0);
        rst_n = 1'b1;
        tick();
        base = frames.size();
        wait_frames(base + 1, 300, 1);
        if (frames.size() > base) begin
            check("retry_frame", 32'(frames[base].data), 32'h833C);
            check("retry_bits",  32'(frames[base].bits), 32'd16);
        end
        repeat (5) tick();

        // Inputs change after grant: the frame keeps the values latched at grant.
        base = frames.size();
        addr0_r = 7'h02; data0_r = 8'hC3; req_r = 2'b01;
        repeat (10) tick();
        req_r = 2'b00; addr0_r = 7'h7F; data0_r = 8'h00;
        wait_frames(base + 1, 300, 1);
        if (frames.size() > base) begin
            check("latched_frame", 32'(frames[base].data), 32'h82C3);
            check("latched_ack",   32'(frames[base].ack_at_rise), 32'd1);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 5000; n++) begin
            tick();
            rst_n = ($urandom_range(0, 599) != 0);
            for (int i = 0; i < 2; i++) begin
                if (req_r[i] && ack[i] && $urandom_range(0, 9) != 0) begin
                    req_r[i] = 1'b0;
                end else if (!req_r[i] && $urandom_range(0, 7) == 0) begin
                    req_r[i] = 1'b1;
                    if (i == 0) begin
                        addr0_r = 7'($urandom_range(0, 6)); data0_r = 8'($urandom);
                    end else begin
                        addr1_r = 7'($urandom_range(0, 6)); data1_r = 8'($urandom);
                    end
                end
                if ($urandom_range(0, 59) == 0) begin
                    if (i == 0) data0_r = 8'($urandom);
                    else        data1_r = 8'($urandom);
                end
            end
        end
        rst_n = 1'b1;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
